// File: rtl/time_pkg.sv
// Shared BCD time-of-day constants and helpers used by the counter chain
// and by the load validation in bcd_time_counter.
package time_pkg;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;

    // Packed BCD increment; callers handle the wrap at their own maximum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Both nibbles decimal, and the value not beyond max_bcd (BCD orders like binary).
    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max_bcd);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_bcd);
    endfunction

    function automatic logic [7:0] int_to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// One BCD digit-pair counter that wraps from MAX_BCD to 00; wrap flags the
// terminal value so the next stage can chain its increment on it.
module bcd_mod_counter
    import time_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       ld,
    input  logic [7:0] ld_val,
    input  logic       inc,
    output logic [7:0] val,
    output logic       wrap
);

    assign wrap = (val == MAX_BCD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            val <= 8'h00;
        else if (clr)
            val <= 8'h00;
        else if (ld)
            val <= ld_val;
        else if (inc)
            val <= wrap ? 8'h00 : bcd_inc(val);
    end

endmodule

// File: rtl/bcd_time_counter.sv
// hh:mm:ss BCD time-of-day counter advanced once per rising edge of the
// synchronized 1 Hz enable level, with run/pause, clear and validated load.
module bcd_time_counter
    import time_pkg::*;
#(
    parameter int SYNC_STAGES = 0,
    parameter int H_MAX       = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_clk_en,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_h,
    input  logic [7:0] load_m,
    input  logic [7:0] load_s,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       tick,
    output logic       min_roll,
    output logic       day_roll,
    output logic       load_err
);

    localparam logic [7:0] H_MAX_BCD = int_to_bcd(H_MAX);

    logic en_s;
    logic prev;
    logic rise;
    logic load_ok;
    logic do_load;
    logic advance;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    // Chain and prev reset to 1 so a level already high at reset release never counts.
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign en_s = slow_clk_en;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= slow_clk_en;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        sync_q[i] <= sync_q[i-1];
                end
            end

            assign en_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prev <= 1'b1;
        else
            prev <= en_s;
    end

    assign rise    = en_s & ~prev;
    assign load_ok = bcd_valid(load_s, SEC_MAX) &&
                     bcd_valid(load_m, MIN_MAX) &&
                     bcd_valid(load_h, H_MAX_BCD);
    assign do_load = ~clear & load & load_ok;
    assign advance = rise & run & ~clear & ~load;

    bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .ld     (do_load),
        .ld_val (load_s),
        .inc    (advance),
        .val    (sec),
        .wrap   (sec_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .ld     (do_load),
        .ld_val (load_m),
        .inc    (advance & sec_wrap),
        .val    (min),
        .wrap   (min_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(H_MAX_BCD)) u_hour (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .ld     (do_load),
        .ld_val (load_h),
        .inc    (advance & sec_wrap & min_wrap),
        .val    (hour),
        .wrap   (hour_wrap)
    );

    // Pulses are registered alongside the counters so they line up with the new time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick     <= 1'b0;
            min_roll <= 1'b0;
            day_roll <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= advance;
            min_roll <= advance & sec_wrap;
            day_roll <= advance & sec_wrap & min_wrap & hour_wrap;
            load_err <= ~clear & load & ~load_ok;
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: a decimal reference model predicts every
// cycle for three instances (default, H_MAX=11, SYNC_STAGES=2).
module tb_bcd_time_counter;

    typedef struct {
        int          d;
        logic [27:0] v;
    } sb_entry_t;

    logic       clk;
    logic       rst;
    logic       slow_clk_en;
    logic       run;
    logic       clear;
    logic       load;
    logic [7:0] load_h;
    logic [7:0] load_m;
    logic [7:0] load_s;

    logic [7:0] hour0, min0, sec0, hour1, min1, sec1, hour2, min2, sec2;
    logic       tick0, mr0, dr0, le0, tick1, mr1, dr1, le1, tick2, mr2, dr2, le2;

    int total = 0;
    int bad   = 0;
    sb_entry_t sb[$];

    // Reference model state, one slot per instance.
    int       h_max[3]  = '{23, 11, 23};
    int       stages[3] = '{0, 0, 2};
    int       m_h[3], m_m[3], m_s[3];
    bit [2:0] m_sync[3];
    bit       m_prev[3];
    bit       m_tick[3], m_mr[3], m_dr[3], m_le[3];

    bcd_time_counter dut (
        .clk(clk), .rst(rst), .slow_clk_en(slow_clk_en), .run(run), .clear(clear),
        .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hour(hour0), .min(min0), .sec(sec0),
        .tick(tick0), .min_roll(mr0), .day_roll(dr0), .load_err(le0)
    );

    bcd_time_counter #(.H_MAX(11)) dut_h11 (
        .clk(clk), .rst(rst), .slow_clk_en(slow_clk_en), .run(run), .clear(clear),
        .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hour(hour1), .min(min1), .sec(sec1),
        .tick(tick1), .min_roll(mr1), .day_roll(dr1), .load_err(le1)
    );

    bcd_time_counter #(.SYNC_STAGES(2)) dut_s2 (
        .clk(clk), .rst(rst), .slow_clk_en(slow_clk_en), .run(run), .clear(clear),
        .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s),
        .hour(hour2), .min(min2), .sec(sec2),
        .tick(tick2), .min_roll(mr2), .day_roll(dr2), .load_err(le2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(n / 10);
        units = 4'(n % 10);
        return {tens, units};
    endfunction

    function automatic bit field_ok(input logic [7:0] b, input int max);
        int value;
        value = int'(b[7:4]) * 10 + int'(b[3:0]);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (value <= max);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_h[d] = 0; m_m[d] = 0; m_s[d] = 0;
            m_sync[d] = 3'b111;
            m_prev[d] = 1'b1;
            m_tick[d] = 0; m_mr[d] = 0; m_dr[d] = 0; m_le[d] = 0;
        end
    endtask

    task automatic model_step();
        bit en_s;
        bit rise;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_h[d] = 0; m_m[d] = 0; m_s[d] = 0;
                m_sync[d] = 3'b111; m_prev[d] = 1'b1;
                m_tick[d] = 0; m_mr[d] = 0; m_dr[d] = 0; m_le[d] = 0;
            end else begin
                en_s = (stages[d] == 0) ? slow_clk_en : m_sync[d][stages[d]-1];
                rise = en_s && !m_prev[d];
                m_sync[d] = {m_sync[d][1:0], slow_clk_en};
                m_prev[d] = en_s;
                m_tick[d] = 0; m_mr[d] = 0; m_dr[d] = 0; m_le[d] = 0;
                if (clear) begin
                    m_h[d] = 0; m_m[d] = 0; m_s[d] = 0;
                end else if (load) begin
                    if (field_ok(load_h, h_max[d]) && field_ok(load_m, 59) && field_ok(load_s, 59)) begin
                        m_h[d] = int'(load_h[7:4]) * 10 + int'(load_h[3:0]);
                        m_m[d] = int'(load_m[7:4]) * 10 + int'(load_m[3:0]);
                        m_s[d] = int'(load_s[7:4]) * 10 + int'(load_s[3:0]);
                    end else begin
                        m_le[d] = 1;
                    end
                end else if (rise && run) begin
                    m_tick[d] = 1;
                    m_s[d]++;
                    if (m_s[d] == 60) begin
                        m_s[d] = 0;
                        m_mr[d] = 1;
                        m_m[d]++;
                        if (m_m[d] == 60) begin
                            m_m[d] = 0;
                            m_h[d]++;
                            if (m_h[d] > h_max[d]) begin
                                m_h[d] = 0;
                                m_dr[d] = 1;
                            end
                        end
                    end
                end
            end
        end
    endtask

    // Each cycle: the model predicts from the inputs the DUTs just sampled.
    task automatic applyStimulus(input int n);
        sb_entry_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            for (int d = 0; d < 3; d++) begin
                e.d = d;
                e.v = {to_bcd(m_h[d]), to_bcd(m_m[d]), to_bcd(m_s[d]),
                       m_tick[d], m_mr[d], m_dr[d], m_le[d]};
                sb.push_back(e);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic en_rise();
        slow_clk_en = 1'b0;
        applyStimulus(3);
        slow_clk_en = 1'b1;
        applyStimulus(3);
    endtask

    always @(negedge clk) begin
        sb_entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.d)
                0:       checkOutput("dut23", {4'h0, hour0, min0, sec0, tick0, mr0, dr0, le0}, {4'h0, e.v});
                1:       checkOutput("dut11", {4'h0, hour1, min1, sec1, tick1, mr1, dr1, le1}, {4'h0, e.v});
                default: checkOutput("sync2", {4'h0, hour2, min2, sec2, tick2, mr2, dr2, le2}, {4'h0, e.v});
            endcase
        end
    end

    initial begin
        int lat0;
        int lat2;
        rst = 1'b1; slow_clk_en = 1'b1; run = 1'b1; clear = 1'b0; load = 1'b0;
        load_h = 8'h00; load_m = 8'h00; load_s = 8'h00;
        model_reset();
        applyStimulus(3);
        checkOutput("reset_state", {4'h0, hour0, min0, sec0, tick0, mr0, dr0, le0}, 32'h0);

        // Level high across reset release, then a real 0->1.
        rst = 1'b0;
        applyStimulus(4);
        checkOutput("t1_no_tick", {31'h0, tick0}, 32'h0);
        slow_clk_en = 1'b0;
        applyStimulus(1);
        slow_clk_en = 1'b1;
        applyStimulus(1);
        checkOutput("t1_sec01", {24'h0, sec0}, 32'h01);
        checkOutput("t1_tick", {31'h0, tick0}, 32'h1);
        applyStimulus(1);
        checkOutput("t1_tick_once", {31'h0, tick0}, 32'h0);

        // Day wrap from 23:59:58.
        slow_clk_en = 1'b0;
        load = 1'b1; load_h = 8'h23; load_m = 8'h59; load_s = 8'h58;
        applyStimulus(1);
        load = 1'b0;
        en_rise();
        en_rise();
        checkOutput("t2_wrap", {8'h0, hour0, min0, sec0}, 32'h0);

        // Rejected loads.
        load = 1'b1; load_h = 8'h12; load_m = 8'h00; load_s = 8'h5A;
        applyStimulus(1);
        checkOutput("t3_err_sec", {31'h0, le0}, 32'h1);
        load = 1'b0;
        applyStimulus(1);
        load = 1'b1; load_h = 8'h24; load_s = 8'h00;
        applyStimulus(1);
        checkOutput("t3_err_hour", {31'h0, le0}, 32'h1);
        load = 1'b0;
        applyStimulus(1);

        // Paused, then resumed with the input already high.
        run = 1'b0;
        en_rise();
        en_rise();
        en_rise();
        run = 1'b1;
        applyStimulus(3);
        en_rise();

        // Load on the rise cycle, then clear beats load.
        slow_clk_en = 1'b0;
        applyStimulus(3);
        slow_clk_en = 1'b1;
        load = 1'b1; load_h = 8'h12; load_m = 8'h34; load_s = 8'h56;
        applyStimulus(1);
        checkOutput("t5_load_on_rise", {8'h0, hour0, min0, sec0}, 32'h123456);
        load = 1'b0;
        applyStimulus(3);
        clear = 1'b1; load = 1'b1;
        applyStimulus(1);
        clear = 1'b0; load = 1'b0;
        applyStimulus(2);

        // Asynchronous reset between edges.
        slow_clk_en = 1'b0;
        load = 1'b1; load_h = 8'h05; load_m = 8'h06; load_s = 8'h07;
        applyStimulus(1);
        load = 1'b0;
        applyStimulus(2);
        rst = 1'b1;
        #1;
        checkOutput("async_rst", {4'h0, hour0, min0, sec0, tick0, mr0, dr0, le0}, 32'h0);
        model_reset();
        #1;
        rst = 1'b0;
        applyStimulus(2);

        // 11:59:59 wraps only for the H_MAX=11 instance.
        load = 1'b1; load_h = 8'h11; load_m = 8'h59; load_s = 8'h59;
        applyStimulus(1);
        load = 1'b0;
        en_rise();
        checkOutput("h11_wrap", {8'h0, hour1, min1, sec1}, 32'h0);
        checkOutput("h23_noon", {8'h0, hour0, min0, sec0}, 32'h120000);

        // Tick latency with and without the extra sync flops.
        slow_clk_en = 1'b0;
        applyStimulus(4);
        slow_clk_en = 1'b1;
        lat0 = -1;
        lat2 = -1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1);
            if (tick0 && lat0 < 0) lat0 = i;
            if (tick2 && lat2 < 0) lat2 = i;
        end
        checkOutput("lat_sync0", 32'(lat0), 32'd0);
        checkOutput("lat_sync2", 32'(lat2), 32'd2);

        applyStimulus(2);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
